// File: rtl/trap_sequencer_pkg.sv
// Shared encodings for the trap sequencer: trap_status codes, mcause values,
// machine-mode CSR addresses and FSM state encoding.
package trap_sequencer_pkg;

  localparam logic [2:0] TS_NONE      = 3'b000;
  localparam logic [2:0] TS_ECALL     = 3'b001;
  localparam logic [2:0] TS_EBREAK    = 3'b010;
  localparam logic [2:0] TS_MRET      = 3'b011;
  localparam logic [2:0] TS_MIS_INSTR = 3'b100;
  localparam logic [2:0] TS_MIS_LOAD  = 3'b101;
  localparam logic [2:0] TS_MIS_STORE = 3'b110;
  localparam logic [2:0] TS_ILLEGAL   = 3'b111;

  localparam logic [3:0] CAUSE_MIS_INSTR = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
  localparam logic [3:0] CAUSE_MIS_LOAD  = 4'd4;
  localparam logic [3:0] CAUSE_MIS_STORE = 4'd6;
  localparam logic [3:0] CAUSE_ECALL     = 4'd11;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STANDBY,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_W_MTVAL,
    ST_R_MTVEC,
    ST_R_MEPC,
    ST_REDIRECT
  } state_t;

endpackage

// File: rtl/trap_cause_encoder.sv
// Combinational decode of trap_status into mcause value and sequencing flags.
// Zero latency; no flow control.
module trap_cause_encoder
  import trap_sequencer_pkg::*;
(
  input  logic [2:0] status_i,
  output logic [3:0] cause_o,
  output logic       needs_standby_o,
  output logic       is_misaligned_o
);

  always_comb begin
    cause_o         = 4'd0;
    needs_standby_o = 1'b0;
    is_misaligned_o = 1'b0;
    case (status_i)
      TS_ECALL:     begin cause_o = CAUSE_ECALL;     needs_standby_o = 1'b1; end
      TS_EBREAK:    begin cause_o = CAUSE_EBREAK;    needs_standby_o = 1'b1; end
      TS_MRET:      needs_standby_o = 1'b1;
      TS_MIS_INSTR: begin cause_o = CAUSE_MIS_INSTR; is_misaligned_o = 1'b1; end
      TS_MIS_LOAD:  begin cause_o = CAUSE_MIS_LOAD;  is_misaligned_o = 1'b1; end
      TS_MIS_STORE: begin cause_o = CAUSE_MIS_STORE; is_misaligned_o = 1'b1; end
      TS_ILLEGAL:   begin cause_o = CAUSE_ILLEGAL;   needs_standby_o = 1'b1; end
      default:      ;
    endcase
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: drain, CSR writes/reads over a ready-gated port, then redirect + flush.
// Optional trap_count output enabled by defining TRAP_COUNTER_EN.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      trap_status,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            csr_ready,
  input  logic [XLEN-1:0] csr_read_data,
  output logic            csr_write_enable,
  output logic            csr_read_enable,
  output logic [11:0]     csr_address,
  output logic [XLEN-1:0] csr_write_data,
  output logic            trap_done,
  output logic            standby_mode,
  output logic            pth_done_flush,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_target
`ifdef TRAP_COUNTER_EN
  ,
  output logic [31:0]     trap_count
`endif
);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            mret_q, mret_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] target_q, target_d;

  logic [3:0] enc_cause;
  logic       enc_standby;
  logic       enc_misaligned;

  trap_cause_encoder u_enc (
    .status_i        (trap_status),
    .cause_o         (enc_cause),
    .needs_standby_o (enc_standby),
    .is_misaligned_o (enc_misaligned)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mret_d   = mret_q;
    cause_d  = cause_q;
    pc_d     = pc_q;
    mtval_d  = mtval_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (trap_status != TS_NONE) begin
          mret_d  = (trap_status == TS_MRET);
          cause_d = enc_cause;
          pc_d    = trap_pc;
          mtval_d = enc_misaligned ? trap_addr : '0;
          if (enc_standby) begin
            state_d = ST_STANDBY;
            cnt_d   = 4'(DRAIN_CYCLES);
          end else begin
            state_d = ST_W_MEPC;
          end
        end
      end
      ST_STANDBY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = mret_q ? ST_R_MEPC : ST_W_MEPC;
      end
      ST_W_MEPC:   if (csr_ready) state_d = ST_W_MCAUSE;
      ST_W_MCAUSE: if (csr_ready) state_d = ST_W_MTVAL;
      ST_W_MTVAL:  if (csr_ready) state_d = ST_R_MTVEC;
      ST_R_MTVEC: begin
        // Direct mode only: the vector mode bits are dropped from the base.
        if (csr_ready) begin
          state_d  = ST_REDIRECT;
          target_d = {csr_read_data[XLEN-1:2], 2'b00};
        end
      end
      ST_R_MEPC: begin
        if (csr_ready) begin
          state_d  = ST_REDIRECT;
          target_d = csr_read_data;
        end
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      mret_q   <= 1'b0;
      cause_q  <= 4'd0;
      pc_q     <= '0;
      mtval_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mret_q   <= mret_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      mtval_q  <= mtval_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    csr_write_enable = 1'b0;
    csr_read_enable  = 1'b0;
    csr_address      = 12'h000;
    csr_write_data   = '0;
    case (state_q)
      ST_W_MEPC: begin
        csr_write_enable = 1'b1;
        csr_address      = CSR_MEPC;
        csr_write_data   = pc_q;
      end
      ST_W_MCAUSE: begin
        csr_write_enable = 1'b1;
        csr_address      = CSR_MCAUSE;
        csr_write_data   = {{(XLEN-4){1'b0}}, cause_q};
      end
      ST_W_MTVAL: begin
        csr_write_enable = 1'b1;
        csr_address      = CSR_MTVAL;
        csr_write_data   = mtval_q;
      end
      ST_R_MTVEC: begin
        csr_read_enable = 1'b1;
        csr_address     = CSR_MTVEC;
      end
      ST_R_MEPC: begin
        csr_read_enable = 1'b1;
        csr_address     = CSR_MEPC;
      end
      default: ;
    endcase
  end

  assign trap_done      = (state_q == ST_IDLE) || (state_q == ST_REDIRECT);
  assign standby_mode   = (state_q == ST_STANDBY);
  assign trap_redirect  = (state_q == ST_REDIRECT);
  assign pth_done_flush = (state_q == ST_REDIRECT);
  assign trap_target    = target_q;

`ifdef TRAP_COUNTER_EN
  logic [31:0] count_q;

  // Only trap entries (redirect via mtvec) are counted; returns via mepc are not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             count_q <= 32'd0;
    else if (state_q == ST_R_MTVEC && csr_ready) count_q <= count_q + 32'd1;
  end

  assign trap_count = count_q;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed table-driven bench for trap_sequencer plus reset and back-to-back corner sequences.
`timescale 1ns/1ps
module tb_trap_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [2:0]      trap_status = 3'b000;
  logic [XLEN-1:0] trap_pc = '0;
  logic [XLEN-1:0] trap_addr = '0;
  logic            csr_ready = 1'b1;
  logic [XLEN-1:0] csr_read_data;
  logic            csr_write_enable, csr_read_enable;
  logic [11:0]     csr_address;
  logic [XLEN-1:0] csr_write_data;
  logic            trap_done, standby_mode, pth_done_flush, trap_redirect;
  logic [XLEN-1:0] trap_target;
`ifdef TRAP_COUNTER_EN
  logic [31:0]     trap_count;
`endif

  logic [XLEN-1:0] rd_val = '0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // CSR file model: returns the value programmed for the current test when read.
  assign csr_read_data = csr_read_enable ? rd_val : '0;

  trap_sequencer #(.XLEN(XLEN), .DRAIN_CYCLES(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .trap_status      (trap_status),
    .trap_pc          (trap_pc),
    .trap_addr        (trap_addr),
    .csr_ready        (csr_ready),
    .csr_read_data    (csr_read_data),
    .csr_write_enable (csr_write_enable),
    .csr_read_enable  (csr_read_enable),
    .csr_address      (csr_address),
    .csr_write_data   (csr_write_data),
    .trap_done        (trap_done),
    .standby_mode     (standby_mode),
    .pth_done_flush   (pth_done_flush),
    .trap_redirect    (trap_redirect),
    .trap_target      (trap_target)
`ifdef TRAP_COUNTER_EN
    ,
    .trap_count       (trap_count)
`endif
  );

  typedef struct {
    logic [2:0]  status;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] rd;
    int          stall;
    logic [31:0] cause;
    logic [31:0] mtval;
    int          standby;
    int          redir;
    logic [31:0] target;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [11:0] wa[4];
    logic [31:0] wd[4];
    logic [11:0] ea[3];
    logic [31:0] ed[3];
    logic [11:0] rda;
    logic [31:0] tgt;
    logic        done_at_redir;
    int nw = 0, sb = 0, redir = -1, flush_n = 0, busy_done = 0;
    int stall_left = v.stall;
    bit is_mret = (v.status == 3'b011);
    rda = 12'h000;
    tgt = '0;
    done_at_redir = 1'b0;
    rd_val = v.rd;
    @(negedge clk);
    trap_status = v.status;
    trap_pc     = v.pc;
    trap_addr   = v.addr;
    csr_ready   = 1'b1;
    @(posedge clk);
    #1;
    trap_status = 3'b000;
    trap_pc     = 32'hFFFF_0000;
    trap_addr   = 32'hFFFF_1111;
    for (int cyc = 1; cyc <= 40 && redir < 0; cyc++) begin
      @(negedge clk);
      csr_ready = 1'b1;
      if (csr_write_enable && csr_address == 12'h341 && stall_left > 0) begin
        csr_ready = 1'b0;
        stall_left--;
        check($sformatf("v%0d stalled mepc data", idx), csr_write_data, v.pc);
      end
      if (standby_mode) sb++;
      if (trap_done && !trap_redirect) busy_done++;
      if (pth_done_flush) flush_n++;
      if (csr_write_enable && csr_ready && nw < 4) begin
        wa[nw] = csr_address;
        wd[nw] = csr_write_data;
        nw++;
      end
      if (csr_read_enable && csr_ready) rda = csr_address;
      if (trap_redirect) begin
        redir = cyc;
        tgt = trap_target;
        done_at_redir = trap_done;
      end
    end
    @(negedge clk);
    if (pth_done_flush) flush_n++;
    check($sformatf("v%0d redirect cycle", idx), redir, v.redir);
    check($sformatf("v%0d target", idx), tgt, v.target);
    check($sformatf("v%0d standby cycles", idx), sb, v.standby);
    check($sformatf("v%0d trap_done while busy", idx), busy_done, 0);
    check($sformatf("v%0d trap_done in redirect", idx), done_at_redir, 1);
    check($sformatf("v%0d flush pulse cycles", idx), flush_n, 1);
    check($sformatf("v%0d target held", idx), trap_target, v.target);
    check($sformatf("v%0d idle after", idx), {trap_done, trap_redirect}, 2'b10);
    if (is_mret) begin
      check($sformatf("v%0d write count", idx), nw, 0);
      check($sformatf("v%0d read addr", idx), rda, 12'h341);
    end else begin
      ea[0] = 12'h341; ed[0] = v.pc;
      ea[1] = 12'h342; ed[1] = v.cause;
      ea[2] = 12'h343; ed[2] = v.mtval;
      check($sformatf("v%0d write count", idx), nw, 3);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("v%0d write%0d addr", idx, i), wa[i], ea[i]);
        check($sformatf("v%0d write%0d data", idx, i), wd[i], ed[i]);
      end
      check($sformatf("v%0d read addr", idx), rda, 12'h305);
    end
  endtask

  initial begin
    int redir;
    int found;
    int idle_ok;

    vecs[0] = '{status:3'b001, pc:32'h100, addr:32'hDEAD, rd:32'h201, stall:0,
                cause:32'd11, mtval:32'h0, standby:2, redir:7, target:32'h200};
    vecs[1] = '{status:3'b101, pc:32'h40, addr:32'h1003, rd:32'h300, stall:0,
                cause:32'd4, mtval:32'h1003, standby:0, redir:5, target:32'h300};
    vecs[2] = '{status:3'b011, pc:32'h55, addr:32'h99, rd:32'h104, stall:0,
                cause:32'd0, mtval:32'h0, standby:2, redir:4, target:32'h104};
    vecs[3] = '{status:3'b111, pc:32'h200, addr:32'h77, rd:32'h403, stall:3,
                cause:32'd2, mtval:32'h0, standby:2, redir:10, target:32'h400};
    vecs[4] = '{status:3'b010, pc:32'h300, addr:32'h5, rd:32'h1002, stall:0,
                cause:32'd3, mtval:32'h0, standby:2, redir:7, target:32'h1000};
    vecs[5] = '{status:3'b110, pc:32'h44, addr:32'h2002, rd:32'hFFFF_FFFF, stall:0,
                cause:32'd6, mtval:32'h2002, standby:0, redir:5, target:32'hFFFF_FFFC};
    vecs[6] = '{status:3'b100, pc:32'h12, addr:32'h13, rd:32'h8, stall:0,
                cause:32'd0, mtval:32'h13, standby:0, redir:5, target:32'h8};

    #2;
    check("reset trap_done", trap_done, 1);
    check("reset 1-bit outputs", {standby_mode, pth_done_flush, trap_redirect,
                                  csr_write_enable, csr_read_enable}, 5'b0);
    check("reset buses", csr_address | csr_write_data | trap_target, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of the mcause write.
    rd_val = 32'h201;
    @(negedge clk);
    trap_status = 3'b001;
    trap_pc     = 32'h500;
    @(posedge clk);
    #1 trap_status = 3'b000;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (csr_write_enable && csr_address == 12'h342) found = 1;
    end
    check("reach mcause write", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst trap_done", trap_done, 1);
    check("async rst 1-bit outputs", {standby_mode, pth_done_flush, trap_redirect,
                                      csr_write_enable, csr_read_enable}, 5'b0);
    check("async rst csr_address", csr_address, 0);
    check("async rst csr_write_data", csr_write_data, 0);
    check("async rst trap_target", trap_target, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle_ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (trap_done && !standby_mode && !csr_write_enable && !csr_read_enable && !trap_redirect)
        idle_ok++;
    end
    check("idle after reset", idle_ok, 5);

    // Back-to-back ECALLs: second request held through REDIRECT.
    rd_val = 32'h201;
    @(negedge clk);
    trap_status = 3'b001;
    trap_pc     = 32'h600;
    @(posedge clk);
    #1 trap_status = 3'b000;
    redir = -1;
    for (int cyc = 1; cyc <= 30 && redir < 0; cyc++) begin
      @(negedge clk);
      if (trap_redirect) redir = cyc;
    end
    check("b2b first redirect cycle", redir, 7);
    trap_status = 3'b001;
    trap_pc     = 32'h700;
    @(negedge clk);
    check("b2b ignored in redirect", {trap_done, standby_mode, trap_redirect}, 3'b100);
    @(posedge clk);
    #1 trap_status = 3'b000;
    @(negedge clk);
    check("b2b accepted next idle", standby_mode, 1);
    redir = -1;
    found = 0;
    for (int cyc = 2; cyc <= 30 && redir < 0; cyc++) begin
      @(negedge clk);
      if (csr_write_enable && csr_address == 12'h341 && csr_write_data == 32'h700) found = 1;
      if (trap_redirect) redir = cyc;
    end
    check("b2b second redirect cycle", redir, 7);
    check("b2b second mepc write", found, 1);
    check("b2b second target", trap_target, 32'h200);
`ifdef TRAP_COUNTER_EN
    @(negedge clk);
    check("trap_count after b2b", trap_count, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Drives the trap-side inputs that the pipeline hazard logic consumes: trap_done, standby_mode and pth_done_flush.
- Accepts an encoded trap request and, for ID-phase traps, drains older instructions first.
- Sequences the machine-mode CSR writes/reads over a ready-gated CSR port, then issues a single-cycle redirect plus full-pipeline flush.
- Sits between the exception detector and the CSR file / PC-select logic.

Parameters:
XLEN, 32, data/address width
DRAIN_CYCLES, 2, standby cycles before CSR sequencing for ID-phase traps (legal range 1..15)

Ports:
clk  input  1  system clock
reset_n  input  1  reset; asynchronous, active-low
trap_status  input  3  encoded trap request, 000 = none; sampled only in IDLE
trap_pc  input  XLEN  PC of the trapping instruction; sampled with trap_status
trap_addr  input  XLEN  faulting data/instruction address for misaligned traps; sampled with trap_status
csr_ready  input  1  CSR file accepts the current write / read data valid
csr_read_data  input  XLEN  combinational read data for csr_address
csr_write_enable  output  1  CSR write request
csr_read_enable  output  1  CSR read request
csr_address  output  12  CSR address
csr_write_data  output  XLEN  CSR write data
trap_done  output  1  high when no trap sequence is holding the pipeline
standby_mode  output  1  stall front end (IF/ID, ID/EX) while back end drains
pth_done_flush  output  1  one-cycle flush of all pipeline registers
trap_redirect  output  1  one-cycle PC redirect strobe
trap_target  output  XLEN  redirect PC; valid when trap_redirect=1

Behaviour:
- trap_status encoding:
  - 000 NONE, 001 ECALL, 010 EBREAK, 011 MRET
  - 100 MISALIGNED_INSTRUCTION, 101 MISALIGNED_LOAD, 110 MISALIGNED_STORE, 111 ILLEGAL
- Cause codes (mcause): ECALL 11, EBREAK 3, MIS_INSTR 0, MIS_LOAD 4, MIS_STORE 6, ILLEGAL 2.
- mtval value: trap_addr for misaligned traps, 0 for all other traps.
- States: IDLE, STANDBY, W_MEPC, W_MCAUSE, W_MTVAL, R_MTVEC, R_MEPC, REDIRECT.
- Transitions out of IDLE (the cycle that sees trap_status != 0 latches status, pc and addr):
  - ECALL, EBREAK, ILLEGAL, MRET -> STANDBY.
  - Misaligned traps -> W_MEPC.
- STANDBY:
  - Internal counter loads DRAIN_CYCLES on entry and is decremented each cycle.
  - After DRAIN_CYCLES cycles: MRET -> R_MEPC, all other traps -> W_MEPC.
- W_MEPC (0x341, latched pc) -> W_MCAUSE (0x342, zero-extended cause) -> W_MTVAL (0x343) -> R_MTVEC (0x305) -> REDIRECT.
- R_MEPC (0x341) -> REDIRECT.
- Handshake:
  - In each W_/R_ state the request and address are held stable until a cycle with csr_ready=1.
  - The state advances only on that cycle.
  - A read captures csr_read_data in that same cycle.
- Redirect target:
  - From R_MTVEC: target = read_data with bits [1:0] cleared (direct mode).
  - From R_MEPC: target = read_data unmodified.
- REDIRECT:
  - Lasts one cycle; trap_redirect=1 and pth_done_flush=1; then -> IDLE.
  - trap_status is ignored in this cycle; the earliest new acceptance is in the following IDLE cycle.
- Output decode (Moore, registered state):
  - trap_done=1 in IDLE and REDIRECT only.
  - standby_mode=1 in STANDBY only.
  - csr_write_enable=1 only in W_ states; csr_read_enable=1 only in R_ states.
  - csr_address/csr_write_data = 0 when no request is active.
- trap_target is registered and holds its last value outside REDIRECT.
- Latency with csr_ready tied 1 (acceptance cycle = 0):
  - ECALL/EBREAK/ILLEGAL: REDIRECT at cycle DRAIN_CYCLES+5.
  - Misaligned: REDIRECT at cycle 5.
  - MRET: REDIRECT at cycle DRAIN_CYCLES+2.
- Changes on trap_status/trap_pc/trap_addr outside IDLE have no effect.
- Reset values (any state, asynchronously):
  - State -> IDLE.
  - trap_done=1; all other 1-bit outputs 0; all bus outputs 0.
  - Latches cleared.

Optional Feature:
- Macro TRAP_COUNTER_EN.
- Defined:
  - Adds output trap_count (32 bits), reset 0.
  - Increments by 1 in each REDIRECT cycle entered from R_MTVEC; MRET does not count.
  - Wraps at 2^32.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared header trap.vh: trap_status encodings.
- Shared header csr.vh: cause codes, CSR addresses (mepc, mcause, mtval, mtvec), state encodings.
- One sub-module: trap_cause_encoder (combinational trap_status -> mcause value, needs-standby flag, is-misaligned flag).

Test Plan:
- ECALL, pc=0x100, mtvec reads 0x201, csr_ready=1 -> standby_mode 2 cycles; writes 0x341=0x100, 0x342=11, 0x343=0; read 0x305; REDIRECT at cycle 7 with trap_target=0x200 and pth_done_flush pulse of 1 cycle.
- MISALIGNED_LOAD, pc=0x40, addr=0x1003 -> no standby; mcause=4, mtval=0x1003; REDIRECT at cycle 5.
- MRET, mepc reads 0x104 -> no CSR writes; REDIRECT at cycle 4 with trap_target=0x104.
- ILLEGAL with csr_ready held 0 for 3 cycles in W_MEPC -> address/data stable; trap_done=0 throughout; REDIRECT delayed by exactly 3 cycles.
- reset_n low during W_MCAUSE -> outputs return to reset values immediately; after release, a trap_status=000 idle stays idle.
- Second ECALL asserted during REDIRECT and held -> ignored in REDIRECT, accepted on the next IDLE cycle; TRAP_COUNTER_EN build shows trap_count=2 after both sequences.
